// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default link parameters,
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int LP_CLKS_PER_BIT = 868;
  localparam int LP_WORD_SIZE    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Received-word bundle: the receiver drives it (master), a consumer samples it (slave).
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int WORD_SIZE = LP_WORD_SIZE
);

  logic [WORD_SIZE-1:0] o_data;
  logic                 o_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_busy;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );

  modport slave (
    input o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );

endinterface

// File: rtl/parity_checker.sv
// Odd-parity generator: o_odd_parity is the bit that makes the total count of ones odd.
module parity_checker #(
  parameter int WORD_SIZE = 8
) (
  input  logic [WORD_SIZE-1:0] i_data,
  output logic                 o_odd_parity
);

  assign o_odd_parity = ~(^i_data);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, optional odd parity,
// frame-error detection with a BREAK state that waits for the line to return high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = LP_CLKS_PER_BIT,
  parameter int WORD_SIZE    = LP_WORD_SIZE,
  parameter int PARITY_EN    = 1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_rx,
  uart_rx_if.master rx_if
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WORD_SIZE) + 1;
  localparam logic [TW-1:0] LP_HALF     = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LP_FULL     = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LP_LAST_BIT = BW'(WORD_SIZE - 1);

  logic                 r_rx_meta, r_rx_sync, r_rx_prev;
  uart_state_t          r_state, w_state_next;
  logic [TW-1:0]        r_timer, w_timer_next;
  logic [BW-1:0]        r_bit_idx, w_bit_idx_next;
  logic [WORD_SIZE-1:0] r_shift, w_shift_next;
  logic                 r_par_bit, w_par_bit_next;
  logic [WORD_SIZE-1:0] r_data;
  logic                 r_valid, r_perr, r_ferr;
  logic                 w_load, w_perr_new, w_ferr_new, w_expected;

  parity_checker #(.WORD_SIZE(WORD_SIZE)) u_parity (
    .i_data       (r_shift),
    .o_odd_parity (w_expected)
  );

  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer + TW'(1);
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_par_bit_next = r_par_bit;
    w_load         = 1'b0;
    w_perr_new     = 1'b0;
    w_ferr_new     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_next   = '0;
        w_bit_idx_next = '0;
        if (r_rx_prev && !r_rx_sync) w_state_next = ST_START;
      end
      ST_START: begin
        if (r_timer == LP_HALF) begin
          w_timer_next = '0;
          w_state_next = r_rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_timer == LP_FULL) begin
          w_timer_next   = '0;
          w_shift_next   = {r_rx_sync, r_shift[WORD_SIZE-1:1]};
          w_bit_idx_next = r_bit_idx + BW'(1);
          if (r_bit_idx == LP_LAST_BIT)
            w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (r_timer == LP_FULL) begin
          w_timer_next   = '0;
          w_par_bit_next = r_rx_sync;
          w_state_next   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_timer == LP_FULL) begin
          w_timer_next = '0;
          w_load       = 1'b1;
          w_perr_new   = (PARITY_EN != 0) && (r_par_bit != w_expected);
          w_ferr_new   = !r_rx_sync;
          w_state_next = r_rx_sync ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        w_timer_next = '0;
        if (r_rx_sync) w_state_next = ST_IDLE;
      end
      default: begin
        w_timer_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Synchronizer resets high so leaving reset on an idle line is never a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_par_bit <= w_par_bit_next;
      r_valid   <= w_load;
      if (w_load) begin
        r_data <= r_shift;
        r_perr <= w_perr_new;
        r_ferr <= w_ferr_new;
      end
    end
  end

  assign rx_if.o_data       = r_data;
  assign rx_if.o_valid      = r_valid;
  assign rx_if.o_parity_err = r_perr;
  assign rx_if.o_frame_err  = r_ferr;
  assign rx_if.o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: one receiver with parity, one without.
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic i_rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  int   cyc = 0;

  int n_vec  = 0;
  int n_miss = 0;

  uart_rx_if #(.WORD_SIZE(8)) if0 ();
  uart_rx_if #(.WORD_SIZE(8)) if1 ();

  uart_rx #(.CLKS_PER_BIT(CPB), .WORD_SIZE(8), .PARITY_EN(1)) u_dut0 (
    .i_clk (clk), .i_rst (i_rst), .i_rx (rx0), .rx_if (if0)
  );
  uart_rx #(.CLKS_PER_BIT(CPB), .WORD_SIZE(8), .PARITY_EN(0)) u_dut1 (
    .i_clk (clk), .i_rst (i_rst), .i_rx (rx1), .rx_if (if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid pulse on the falling edge.
  int v0_cnt = 0, v1_cnt = 0, v0_cyc = 0, v1_cyc = 0;
  logic [7:0] v0_data = '0, v1_data = '0;
  logic v0_perr = 1'b0, v0_ferr = 1'b0, v1_perr = 1'b0, v1_ferr = 1'b0;

  always @(negedge clk) begin
    if (if0.o_valid === 1'b1) begin
      v0_cnt++; v0_cyc = cyc; v0_data = if0.o_data;
      v0_perr = if0.o_parity_err; v0_ferr = if0.o_frame_err;
    end
    if (if1.o_valid === 1'b1) begin
      v1_cnt++; v1_cyc = cyc; v1_data = if1.o_data;
      v1_perr = if1.o_parity_err; v1_ferr = if1.o_frame_err;
    end
  end

  // Drives one frame starting at the current time (caller is #1 after a rising edge).
  task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                            input bit par, input bit stop, output int t_start);
    logic bits [0:10];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (has_par) begin bits[nb] = par; nb++; end
    bits[nb] = stop; nb++;
    t_start = cyc;
    for (int i = 0; i < nb; i++) begin
      if (sel == 0) rx0 = bits[i]; else rx1 = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_frame0(input string name, input int c0, input logic [7:0] d,
                            input logic pe, input logic fe);
    n_vec++;
    if (v0_cnt !== c0 + 1) begin
      n_miss++; $display("FAIL %s count: got %0d want %0d", name, v0_cnt - c0, 1);
    end
    n_vec++;
    if (v0_data !== d) begin
      n_miss++; $display("FAIL %s data: got %02h want %02h", name, v0_data, d);
    end
    n_vec++;
    if (v0_perr !== pe) begin
      n_miss++; $display("FAIL %s parity_err: got %0b want %0b", name, v0_perr, pe);
    end
    n_vec++;
    if (v0_ferr !== fe) begin
      n_miss++; $display("FAIL %s frame_err: got %0b want %0b", name, v0_ferr, fe);
    end
  endtask

  task automatic test_reset;
    rx0 = 1'b1; rx1 = 1'b1; i_rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if ({if0.o_data, if0.o_valid, if0.o_parity_err, if0.o_frame_err, if0.o_busy} !== 12'h000) begin
      n_miss++; $display("FAIL reset_outputs: got data=%02h v=%0b pe=%0b fe=%0b busy=%0b want all 0",
                         if0.o_data, if0.o_valid, if0.o_parity_err, if0.o_frame_err, if0.o_busy);
    end
    i_rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_vec++;
    if (if0.o_busy !== 1'b0 || if1.o_busy !== 1'b0 || v0_cnt !== 0) begin
      n_miss++; $display("FAIL reset_release: got busy0=%0b busy1=%0b valids=%0d want 0 0 0",
                         if0.o_busy, if1.o_busy, v0_cnt);
    end
    $display("reset: outputs idle after release");
  endtask

  task automatic test_basic;
    int c0, t0;
    c0 = v0_cnt;
    @(posedge clk); #1;
    send_frame(0, 8'hA5, 1, 1'b1, 1'b1, t0);
    repeat (2) @(posedge clk); #1;
    chk_frame0("basic_A5", c0, 8'hA5, 1'b0, 1'b0);
    // start edge +2 sync +1 detect, half bit, then 10 full bits to the stop sample
    n_vec++;
    if (v0_cyc - t0 !== 171) begin
      n_miss++; $display("FAIL basic_latency: got %0d want %0d", v0_cyc - t0, 171);
    end
    $display("basic: sent A5 got %02h pe=%0b fe=%0b lat=%0d", v0_data, v0_perr, v0_ferr, v0_cyc - t0);
  endtask

  task automatic test_parity;
    int c0, t0;
    c0 = v0_cnt;
    @(posedge clk); #1;
    send_frame(0, 8'h01, 1, 1'b1, 1'b1, t0);
    repeat (2) @(posedge clk); #1;
    chk_frame0("parity_bad", c0, 8'h01, 1'b1, 1'b0);
    $display("parity: sent 01 p=1 got %02h pe=%0b", v0_data, v0_perr);
    c0 = v0_cnt;
    send_frame(0, 8'h01, 1, 1'b0, 1'b1, t0);
    repeat (2) @(posedge clk); #1;
    chk_frame0("parity_good", c0, 8'h01, 1'b0, 1'b0);
    $display("parity: sent 01 p=0 got %02h pe=%0b", v0_data, v0_perr);
  endtask

  task automatic test_glitch;
    int c0, t0, waited;
    c0 = v0_cnt;
    @(posedge clk); #1;
    rx0 = 1'b0;
    repeat (4) @(posedge clk); #1;
    rx0 = 1'b1;
    n_vec++;
    if (if0.o_busy !== 1'b1) begin
      n_miss++; $display("FAIL glitch_busy_high: got %0b want 1", if0.o_busy);
    end
    waited = 0;
    while (if0.o_busy === 1'b1 && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    n_vec++;
    if (if0.o_busy !== 1'b0) begin
      n_miss++; $display("FAIL glitch_busy_fall: got busy=%0b after %0d cycles want 0", if0.o_busy, waited);
    end
    repeat (32) @(posedge clk); #1;
    n_vec++;
    if (v0_cnt !== c0) begin
      n_miss++; $display("FAIL glitch_no_valid: got %0d pulses want 0", v0_cnt - c0);
    end
    $display("glitch: busy cleared after %0d cycles, pulses=%0d", waited, v0_cnt - c0);
    c0 = v0_cnt;
    send_frame(0, 8'h3C, 1, 1'b1, 1'b1, t0);
    repeat (2) @(posedge clk); #1;
    chk_frame0("glitch_next_3C", c0, 8'h3C, 1'b0, 1'b0);
    $display("glitch: next frame got %02h", v0_data);
  endtask

  task automatic test_break;
    int c0, t0;
    c0 = v0_cnt;
    @(posedge clk); #1;
    send_frame(0, 8'h55, 1, 1'b1, 1'b0, t0);
    repeat (40) @(posedge clk); #1;
    chk_frame0("break_55", c0, 8'h55, 1'b0, 1'b1);
    n_vec++;
    if (if0.o_busy !== 1'b1) begin
      n_miss++; $display("FAIL break_hold_busy: got %0b want 1", if0.o_busy);
    end
    rx0 = 1'b1;
    repeat (5) @(posedge clk); #1;
    n_vec++;
    if (if0.o_busy !== 1'b0 || v0_cnt !== c0 + 1) begin
      n_miss++; $display("FAIL break_release: got busy=%0b pulses=%0d want 0 1", if0.o_busy, v0_cnt - c0);
    end
    $display("break: got %02h fe=%0b, released busy=%0b", v0_data, v0_ferr, if0.o_busy);
    c0 = v0_cnt;
    send_frame(0, 8'hFF, 1, 1'b1, 1'b1, t0);
    repeat (2) @(posedge clk); #1;
    chk_frame0("break_next_FF", c0, 8'hFF, 1'b0, 1'b0);
    $display("break: next frame got %02h", v0_data);
  endtask

  task automatic test_reset_mid;
    int c0, t0;
    c0 = v0_cnt;
    @(posedge clk); #1;
    rx0 = 1'b0;
    // start bit, data bits 0..2 and half of bit 3, all zero for 0x80
    repeat (CPB * 4 + CPB / 2) @(posedge clk);
    #1;
    n_vec++;
    if (if0.o_busy !== 1'b1) begin
      n_miss++; $display("FAIL midreset_busy_before: got %0b want 1", if0.o_busy);
    end
    i_rst = 1'b1; rx0 = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_vec++;
    if ({if0.o_data, if0.o_valid, if0.o_parity_err, if0.o_frame_err, if0.o_busy} !== 12'h000) begin
      n_miss++; $display("FAIL midreset_outputs: got data=%02h v=%0b pe=%0b fe=%0b busy=%0b want all 0",
                         if0.o_data, if0.o_valid, if0.o_parity_err, if0.o_frame_err, if0.o_busy);
    end
    i_rst = 1'b0;
    repeat (CPB * 12) @(posedge clk); #1;
    n_vec++;
    if (v0_cnt !== c0 || if0.o_busy !== 1'b0) begin
      n_miss++; $display("FAIL midreset_no_valid: got pulses=%0d busy=%0b want 0 0", v0_cnt - c0, if0.o_busy);
    end
    $display("midreset: outputs cleared, pulses=%0d", v0_cnt - c0);
    send_frame(0, 8'h80, 1, 1'b0, 1'b1, t0);
    repeat (2) @(posedge clk); #1;
    chk_frame0("midreset_next_80", c0, 8'h80, 1'b0, 1'b0);
    $display("midreset: next frame got %02h", v0_data);
  endtask

  task automatic test_back_to_back;
    int c0, c1, t0;
    logic [7:0] dv [3];
    logic       pv [3];
    dv = '{8'h12, 8'h34, 8'h56};
    pv = '{1'b1, 1'b0, 1'b1};
    c0 = v0_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      send_frame(0, dv[i], 1, pv[i], 1'b1, t0);
      n_vec++;
      if (v0_data !== dv[i] || v0_perr !== 1'b0 || v0_ferr !== 1'b0 || v0_cnt !== c0 + i + 1) begin
        n_miss++; $display("FAIL b2b_%0d: got data=%02h pe=%0b fe=%0b pulses=%0d want %02h 0 0 %0d",
                           i, v0_data, v0_perr, v0_ferr, v0_cnt - c0, dv[i], i + 1);
      end
      $display("b2b: frame %0d got %02h", i, v0_data);
    end
    c1 = v1_cnt;
    @(posedge clk); #1;
    send_frame(1, 8'h96, 0, 1'b0, 1'b1, t0);
    repeat (2) @(posedge clk); #1;
    n_vec++;
    if (v1_cnt !== c1 + 1 || v1_data !== 8'h96 || v1_perr !== 1'b0 || v1_ferr !== 1'b0) begin
      n_miss++; $display("FAIL nopar_96: got pulses=%0d data=%02h pe=%0b fe=%0b want 1 96 0 0",
                         v1_cnt - c1, v1_data, v1_perr, v1_ferr);
    end
    n_vec++;
    if (v1_cyc - t0 !== 155) begin
      n_miss++; $display("FAIL nopar_latency: got %0d want %0d", v1_cyc - t0, 155);
    end
    n_vec++;
    if ((v0_cnt - c0) + (v1_cnt - c1) !== 4) begin
      n_miss++; $display("FAIL b2b_total: got %0d pulses want 4", (v0_cnt - c0) + (v1_cnt - c1));
    end
    $display("nopar: got %02h lat=%0d", v1_data, v1_cyc - t0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_break();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have a parameter CLKS_PER_BIT, default 868, giving i_clk cycles per UART bit (minimum 8).
REQ-002 The module SHALL have a parameter WORD_SIZE, default 8, giving the number of data bits per frame.
REQ-003 The module SHALL have a parameter PARITY_EN, default 1; when 1, a parity bit follows the data bits, and when 0 there is no parity bit.
REQ-004 i_clk  input  1  sole clock; all logic is rising-edge.
REQ-005 i_rst  input  1  reset, synchronous to i_clk, active-high.
REQ-006 i_rx  input  1  asynchronous serial line; idle high.
REQ-007 o_data  output  WORD_SIZE  last received word, LSB first on the wire.
REQ-008 o_valid  output  1  one-cycle pulse; o_data and the error flags are valid.
REQ-009 o_parity_err  output  1  received parity bit differs from the expected odd-parity bit; qualified by o_valid.
REQ-010 o_frame_err  output  1  stop bit sampled low; qualified by o_valid.
REQ-011 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 i_rx SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, and BREAK.
REQ-014 IDLE SHALL go to START on a synchronized high-to-low transition and clear the bit-timer.
REQ-015 START SHALL sample at timer = CLKS_PER_BIT/2-1: low goes to DATA with the timer restarted, and high (glitch) goes to IDLE with no o_valid.
REQ-016 DATA, PARITY and STOP SHALL each sample once per bit at timer = CLKS_PER_BIT-1, which is mid-bit relative to the start-bit centre.
REQ-017 DATA SHALL shift samples into the word LSB-first; after WORD_SIZE samples it SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-018 Expected parity SHALL be odd parity: the expected bit is 1 when the data holds an even number of ones, else 0; o_parity_err = (sampled bit != expected).
REQ-019 When PARITY_EN=0, o_parity_err SHALL always be 0.
REQ-020 On the STOP sample, the cycle after it SHALL assert o_valid for exactly one cycle with the new o_data, o_parity_err and o_frame_err.
REQ-021 When the STOP sample is high, the FSM SHALL return to IDLE and can detect a new start edge on the very next cycle.
REQ-022 When the STOP sample is low, it SHALL set o_frame_err=1, still pulse o_valid, and go to BREAK.
REQ-023 BREAK SHALL stay until the synchronized line is high, then go to IDLE with no further o_valid.
REQ-024 o_data and the error flags SHALL hold their values until the next o_valid.
REQ-025 There SHALL be no backpressure; a consumer that misses the o_valid pulse loses the word.
REQ-026 The bit-timer SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never wrap mid-bit.
REQ-027 The bit-index counter SHALL be $clog2(WORD_SIZE)+1 bits wide.

Reset
REQ-028 i_rst SHALL force the state to IDLE, the timers and counters to 0, o_data to 0, and o_valid, o_parity_err, o_frame_err and o_busy to 0.
REQ-029 The synchronizer flops SHALL reset to 1 (idle line), so deasserting reset never produces a false start.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; no o_valid results from it.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state encoding, the default CLKS_PER_BIT and the default WORD_SIZE; these SHALL also be used by uart_tx.
REQ-032 Expected parity SHALL come from one instance of the existing parity_checker (WORD_SIZE passed through) on the assembled word; no other sub-modules.

Verification (CLKS_PER_BIT=16, WORD_SIZE=8, PARITY_EN=1 unless noted)
REQ-033 Send frame 0xA5 with parity 1 and stop 1 -> one o_valid, o_data=0xA5, o_parity_err=0, o_frame_err=0, o_valid 1 cycle after the stop mid-sample.
REQ-034 Send 0x01 with parity 1 -> o_data=0x01, o_parity_err=1; then send 0x01 with parity 0 -> o_parity_err=0.
REQ-035 Hold i_rx low for 4 cycles, then high -> no o_valid, o_busy falls back to 0 within 10 cycles, and a following 0x3C frame is received correctly.
REQ-036 Send 0x55 with stop 0 and hold the line low 40 cycles -> o_valid with o_frame_err=1 and o_data=0x55; no start is detected until the line goes high; the next frame 0xFF is received correctly.
REQ-037 Assert i_rst during the DATA bit 3 of a frame -> outputs go to their reset values, no o_valid; a following 0x80 frame is received correctly.
REQ-038 Send frames 0x12, 0x34 and 0x56 back-to-back with no idle bits, plus 0x96 with PARITY_EN=0 -> four o_valid pulses with the correct data and no error flags.
